// File: rtl/bimodal_btb_predictor.sv
// bimodal_btb_predictor: direct-mapped BTB with per-entry saturating direction
// counters. Predicts the next fetch PC combinationally and trains from EX.
// Ports: i_clk, i_reset (async, active-low); lookup i_pc_if -> o_next_pc_pred,
//   o_pred_taken, o_hit; training i_upd_vld, i_pc_ex, i_actual_taken,
//   i_target_addr, i_is_jump, i_is_call, i_is_ret; statistics i_stall,
//   i_mispredict -> o_lookup_cnt, o_mispred_cnt.
// Optional feature macro RAS_EN: return-address stack for return entries.
module bimodal_btb_predictor #(
   parameter int ENTRIES   = 64,
   parameter int TAG_W     = 8,
   parameter int CTR_W     = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic [31:0] i_pc_if,
   output logic [31:0] o_next_pc_pred,
   output logic        o_pred_taken,
   output logic        o_hit,
   input  logic        i_upd_vld,
   input  logic [31:0] i_pc_ex,
   input  logic        i_actual_taken,
   input  logic [31:0] i_target_addr,
   input  logic        i_is_jump,
   input  logic        i_is_call,
   input  logic        i_is_ret,
   input  logic        i_mispredict,
   output logic [31:0] o_lookup_cnt,
   output logic [31:0] o_mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_RST = CTR_WT - CTR_ONE;

   logic [ENTRIES-1:0] vld_q;
   logic [1:0]         typ_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [29:0]        tgt_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];

   logic [IDX_W-1:0] idx_if, idx_ex;
   logic [TAG_W-1:0] tag_if, tag_ex;
   logic             hit_if, hit_ex;
   logic [31:0]      tgt_if;
   logic [CTR_W-1:0] ctr_ex, ctr_d;
   logic [1:0]       typ_new;
   logic [31:0]      lookup_cnt_q, lookup_cnt_d;
   logic [31:0]      mispred_cnt_q, mispred_cnt_d;

`ifdef RAS_EN
   localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);
   localparam logic [RP_W:0]   RC_ONE = (RP_W + 1)'(1);
   localparam logic [RP_W:0]   RC_MAX = (RP_W + 1)'(RAS_DEPTH);
   logic [31:0]   ras_q [RAS_DEPTH];
   logic [RP_W-1:0] sp_q, sp_pop, sp_d;
   logic [RP_W:0]   ras_cnt_q, cnt_pop, ras_cnt_d;
   logic          ras_pop, ras_push;
   logic [31:0]   ras_top;
   assign ras_top = ras_q[sp_q - RP_ONE];
`endif

   assign idx_if = i_pc_if[IDX_W+1:2];
   assign tag_if = i_pc_if[IDX_W+TAG_W+1:IDX_W+2];
   assign idx_ex = i_pc_ex[IDX_W+1:2];
   assign tag_ex = i_pc_ex[IDX_W+TAG_W+1:IDX_W+2];

   assign hit_if = vld_q[idx_if] && (tag_q[idx_if] == tag_if);
   assign hit_ex = vld_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

   always_comb begin
      tgt_if = {tgt_q[idx_if], 2'b00};
`ifdef RAS_EN
      // An empty stack falls back to the last trained return target.
      if (typ_q[idx_if] == 2'd2 && ras_cnt_q != '0)
         tgt_if = ras_top;
`endif
   end

   assign o_hit = hit_if;
   assign o_pred_taken = hit_if &&
      (typ_q[idx_if] != 2'd0 || ctr_q[idx_if][CTR_W-1]);
   assign o_next_pc_pred = o_pred_taken ? tgt_if : i_pc_if + 32'd4;

   assign ctr_ex = ctr_q[idx_ex];

   always_comb begin
      ctr_d = ctr_ex;
      if (i_actual_taken) begin
         if (ctr_ex != CTR_MAX) ctr_d = ctr_ex + CTR_ONE;
      end else if (ctr_ex != '0) begin
         ctr_d = ctr_ex - CTR_ONE;
      end
   end

`ifdef RAS_EN
   assign typ_new = i_is_ret ? 2'd2 : (i_is_jump ? 2'd1 : 2'd0);
`else
   assign typ_new = i_is_jump ? 2'd1 : 2'd0;
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         vld_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            typ_q[i] <= 2'd0;
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= CTR_RST;
         end
      end else if (i_upd_vld) begin
         if (hit_ex) begin
            ctr_q[idx_ex] <= ctr_d;
            if (i_actual_taken) tgt_q[idx_ex] <= i_target_addr[31:2];
         end else if (i_actual_taken) begin
            vld_q[idx_ex] <= 1'b1;
            typ_q[idx_ex] <= typ_new;
            tag_q[idx_ex] <= tag_ex;
            tgt_q[idx_ex] <= i_target_addr[31:2];
            ctr_q[idx_ex] <= CTR_WT;
         end
      end
   end

`ifdef RAS_EN
   // Pop is applied first so a combined call/return replaces the top.
   assign ras_pop  = i_upd_vld && i_is_ret && (ras_cnt_q != '0);
   assign ras_push = i_upd_vld && i_is_call;
   assign sp_pop   = ras_pop ? sp_q - RP_ONE : sp_q;
   assign cnt_pop  = ras_pop ? ras_cnt_q - RC_ONE : ras_cnt_q;

   always_comb begin
      sp_d      = sp_pop;
      ras_cnt_d = cnt_pop;
      if (ras_push) begin
         sp_d = sp_pop + RP_ONE;
         if (cnt_pop != RC_MAX) ras_cnt_d = cnt_pop + RC_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sp_q      <= '0;
         ras_cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         sp_q      <= sp_d;
         ras_cnt_q <= ras_cnt_d;
         if (ras_push) ras_q[sp_pop] <= i_pc_ex + 32'd4;
      end
   end
`endif

   assign lookup_cnt_d  = lookup_cnt_q + (i_stall ? 32'd0 : 32'd1);
   assign mispred_cnt_d = mispred_cnt_q + (i_mispredict ? 32'd1 : 32'd0);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         lookup_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         lookup_cnt_q  <= lookup_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign o_lookup_cnt  = lookup_cnt_q;
   assign o_mispred_cnt = mispred_cnt_q;

   logic unused_bits;
   assign unused_bits = ^{i_pc_if, i_pc_ex, i_target_addr[1:0],
                          i_is_call, i_is_ret};
endmodule
